// File: rtl/flag_unit.sv
// flag_unit: EX-to-WB status flag pipe with forwarding, flush/stall and interrupt shadow; ports clk, rst, alu_flags, flag_wr_en, flag_wr_mask, stall, flush, save_req, restore_req -> flags_out, flags_arch, pending_cnt, flags_busy
module flag_unit #(
  parameter int DEPTH  = 2,
  parameter int NFLAGS = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NFLAGS-1:0] alu_flags,
  input  logic              flag_wr_en,
  input  logic [NFLAGS-1:0] flag_wr_mask,
  input  logic              stall,
  input  logic              flush,
  input  logic              save_req,
  input  logic              restore_req,
  output logic [NFLAGS-1:0] flags_out,
  output logic [NFLAGS-1:0] flags_arch,
  output logic [2:0]        pending_cnt,
  output logic              flags_busy
);
  localparam int FL_TRUE = 0;
  localparam logic [NFLAGS-1:0] RST_FLAGS = NFLAGS'(1) << FL_TRUE;
  logic [NFLAGS-1:0] arch, shadow, arch_c, arch_nx, fwd;
  logic [DEPTH-1:0]  v;
  logic [NFLAGS-1:0] m [DEPTH];
  logic [NFLAGS-1:0] d [DEPTH];
  logic              kill, adv;
  assign kill = restore_req || flush;
  assign adv  = kill || !stall;
  always_comb begin
    arch_c = v[DEPTH-1] ? (arch & ~m[DEPTH-1]) | (d[DEPTH-1] & m[DEPTH-1]) : arch;
    arch_c[FL_TRUE] = 1'b1;
    arch_nx = restore_req ? shadow : adv ? arch_c : arch;
    fwd = arch;
    for (int k = DEPTH - 1; k >= 0; k--) fwd = v[k] ? (fwd & ~m[k]) | (d[k] & m[k]) : fwd;
    fwd[FL_TRUE] = 1'b1;
    pending_cnt = '0;
    for (int k = 0; k < DEPTH; k++) pending_cnt = pending_cnt + 3'(v[k]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      arch   <= RST_FLAGS;
      shadow <= RST_FLAGS;
      v      <= '0;
    end else begin
      arch <= arch_nx;
      // shadow captures the post-commit value; a simultaneous restore keeps it intact
      if (save_req && !restore_req) shadow <= arch_nx;
      if (adv) begin
        for (int k = DEPTH - 1; k > 0; k--) begin
          v[k] <= v[k-1] && !kill;
          m[k] <= m[k-1];
          d[k] <= d[k-1];
        end
        v[0] <= flag_wr_en && !kill;
        m[0] <= flag_wr_mask;
        d[0] <= alu_flags;
      end
    end
  end
  assign flags_out  = fwd;
  assign flags_arch = arch;
  assign flags_busy = |v;
endmodule
